// File: rtl/rb_reg_bank.sv
// Register bank on the generic register bus: CTRL, STATUS, IRQ_STAT (W1C), IRQ_EN, SCRATCH
// and a saturating event counter, with one-shot SYNC acknowledges per read/write access.
module rb_reg_bank #(
    parameter int unsigned IRQ_W    = 8,
    parameter int unsigned CNT_W    = 16,
    parameter logic [31:0] CTRL_RST = 32'h0000_0000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             rstrobe,
    input  logic [7:0]       raddr,
    output logic [31:0]      rdata,
    output logic             rack,
    output logic             raddrerr,
    input  logic             wstrobe,
    input  logic [7:0]       waddr,
    input  logic [31:0]      wdata,
    output logic             wack,
    output logic             waddrerr,
    input  logic [31:0]      status_i,
    input  logic [IRQ_W-1:0] irq_src_i,
    input  logic             evt_i,
    output logic [31:0]      ctrl_o,
    output logic             irq_o
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 8;
    localparam int unsigned IDX_W  = ADDR_W - 2;

    localparam logic [IDX_W-1:0] IDX_CTRL     = IDX_W'(0);
    localparam logic [IDX_W-1:0] IDX_STATUS   = IDX_W'(1);
    localparam logic [IDX_W-1:0] IDX_IRQ_STAT = IDX_W'(2);
    localparam logic [IDX_W-1:0] IDX_IRQ_EN   = IDX_W'(3);
    localparam logic [IDX_W-1:0] IDX_SCRATCH  = IDX_W'(4);
    localparam logic [IDX_W-1:0] IDX_CNT      = IDX_W'(5);

    logic [DATA_W-1:0] status_q;
    logic [DATA_W-1:0] scratch_q;
    logic [IRQ_W-1:0]  irq_stat_q;
    logic [IRQ_W-1:0]  irq_en_q;
    logic [IRQ_W-1:0]  irq_prev_q;
    logic [CNT_W-1:0]  cnt_q;

    // A "done" flag per direction keeps a strobe held past its ack from re-firing.
    logic rdone_q;
    logic wdone_q;
    logic rd_fire;
    logic wr_fire;

    assign rd_fire = rstrobe & ~rack & ~rdone_q;
    assign wr_fire = wstrobe & ~wack & ~wdone_q;

    logic [DATA_W-1:0] rd_val;
    logic              rd_err;

    always_comb begin
        rd_val = '0;
        rd_err = 1'b0;
        if (raddr[1:0] != 2'b00) begin
            rd_err = 1'b1;
        end else begin
            case (raddr[ADDR_W-1:2])
                IDX_CTRL:     rd_val = ctrl_o;
                IDX_STATUS:   rd_val = status_q;
                IDX_IRQ_STAT: rd_val = DATA_W'(irq_stat_q);
                IDX_IRQ_EN:   rd_val = DATA_W'(irq_en_q);
                IDX_SCRATCH:  rd_val = scratch_q;
                IDX_CNT:      rd_val = DATA_W'(cnt_q);
                default:      rd_err = 1'b1;
            endcase
        end
    end

    logic wr_err;
    logic we_ctrl;
    logic we_stat;
    logic we_en;
    logic we_scratch;
    logic we_cnt;

    // STATUS is read-only, so a write to it falls into the error default.
    always_comb begin
        wr_err     = 1'b0;
        we_ctrl    = 1'b0;
        we_stat    = 1'b0;
        we_en      = 1'b0;
        we_scratch = 1'b0;
        we_cnt     = 1'b0;
        if (wr_fire) begin
            if (waddr[1:0] != 2'b00) begin
                wr_err = 1'b1;
            end else begin
                case (waddr[ADDR_W-1:2])
                    IDX_CTRL:     we_ctrl    = 1'b1;
                    IDX_IRQ_STAT: we_stat    = 1'b1;
                    IDX_IRQ_EN:   we_en      = 1'b1;
                    IDX_SCRATCH:  we_scratch = 1'b1;
                    IDX_CNT:      we_cnt     = 1'b1;
                    default:      wr_err     = 1'b1;
                endcase
            end
        end
    end

    logic [IRQ_W-1:0] irq_rise;
    logic [IRQ_W-1:0] irq_clr;

    assign irq_rise = irq_src_i & ~irq_prev_q;
    assign irq_clr  = we_stat ? wdata[IRQ_W-1:0] : '0;

    // Read handshake: data and error are captured on the firing edge and shown with rack.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rack     <= 1'b0;
            rdone_q  <= 1'b0;
            rdata    <= '0;
            raddrerr <= 1'b0;
        end else begin
            rack     <= rd_fire;
            rdone_q  <= rstrobe & (rdone_q | rd_fire);
            rdata    <= rd_fire ? rd_val : '0;
            raddrerr <= rd_fire & rd_err;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wack     <= 1'b0;
            wdone_q  <= 1'b0;
            waddrerr <= 1'b0;
        end else begin
            wack     <= wr_fire;
            wdone_q  <= wstrobe & (wdone_q | wr_fire);
            waddrerr <= wr_fire & wr_err;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl_o    <= CTRL_RST;
            scratch_q <= '0;
            irq_en_q  <= '0;
            status_q  <= '0;
        end else begin
            status_q <= status_i;
            if (we_ctrl)    ctrl_o    <= wdata;
            if (we_scratch) scratch_q <= wdata;
            if (we_en)      irq_en_q  <= wdata[IRQ_W-1:0];
        end
    end

    // A new edge in the same cycle as a W1C clear wins over the clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_prev_q <= '0;
            irq_stat_q <= '0;
            irq_o      <= 1'b0;
        end else begin
            irq_prev_q <= irq_src_i;
            irq_stat_q <= (irq_stat_q & ~irq_clr) | irq_rise;
            irq_o      <= |(irq_stat_q & irq_en_q);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (we_cnt) begin
            cnt_q <= '0;
        end else if (evt_i && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_rb_reg_bank.sv
// Bench for rb_reg_bank: directed scenarios plus randomized traffic, every cycle compared
// against a transaction-level reference model of the register map.
module tb_rb_reg_bank;

    localparam int unsigned IRQ_W    = 8;
    localparam int unsigned CNT_W    = 10;
    localparam logic [31:0] CTRL_RST = 32'h1234_0001;
    localparam int unsigned CNT_MAX  = (1 << CNT_W) - 1;

    logic             clk;
    logic             reset;
    logic             rstrobe;
    logic [7:0]       raddr;
    logic [31:0]      rdata;
    logic             rack;
    logic             raddrerr;
    logic             wstrobe;
    logic [7:0]       waddr;
    logic [31:0]      wdata;
    logic             wack;
    logic             waddrerr;
    logic [31:0]      status_i;
    logic [IRQ_W-1:0] irq_src_i;
    logic             evt_i;
    logic [31:0]      ctrl_o;
    logic             irq_o;

    rb_reg_bank #(.IRQ_W(IRQ_W), .CNT_W(CNT_W), .CTRL_RST(CTRL_RST)) dut (
        .clk(clk), .reset(reset),
        .rstrobe(rstrobe), .raddr(raddr), .rdata(rdata), .rack(rack), .raddrerr(raddrerr),
        .wstrobe(wstrobe), .waddr(waddr), .wdata(wdata), .wack(wack), .waddrerr(waddrerr),
        .status_i(status_i), .irq_src_i(irq_src_i), .evt_i(evt_i),
        .ctrl_o(ctrl_o), .irq_o(irq_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got 0x%08h expected 0x%08h", tag, $time, obs, exp);
        end
    endtask

    // Reference model: register contents plus whether each strobe was high last cycle.
    logic [31:0]      m_ctrl, m_scratch, m_status;
    logic [IRQ_W-1:0] m_stat, m_en, m_prev;
    int unsigned      m_cnt;
    bit               r_was_hi, w_was_hi;
    logic             e_rack, e_raddrerr, e_wack, e_waddrerr, e_irq;
    logic [31:0]      e_rdata;

    task automatic model_reset();
        m_ctrl = CTRL_RST; m_scratch = '0; m_status = '0;
        m_stat = '0; m_en = '0; m_prev = '0; m_cnt = 0;
        r_was_hi = 0; w_was_hi = 0;
        e_rack = 0; e_raddrerr = 0; e_wack = 0; e_waddrerr = 0; e_irq = 0; e_rdata = '0;
    endtask

    function automatic void model_read(input logic [7:0] a, output logic [31:0] v, output logic e);
        v = '0;
        e = 1'b0;
        case (a)
            8'h00:   v = m_ctrl;
            8'h04:   v = m_status;
            8'h08:   v = 32'(m_stat);
            8'h0C:   v = 32'(m_en);
            8'h10:   v = m_scratch;
            8'h14:   v = m_cnt;
            default: e = 1'b1;
        endcase
    endfunction

    // Effect of the coming clock edge given the inputs currently driven.
    task automatic model_step();
        logic [31:0]      rv;
        logic             re;
        logic [IRQ_W-1:0] clr;
        bit               cnt_clr;
        if (reset) begin
            model_reset();
            return;
        end
        e_irq  = |(m_stat & m_en);
        e_rack = rstrobe && !r_was_hi;
        model_read(raddr, rv, re);
        e_rdata    = e_rack ? rv : '0;
        e_raddrerr = e_rack && re;
        e_wack     = wstrobe && !w_was_hi;
        e_waddrerr = 1'b0;
        clr        = '0;
        cnt_clr    = 0;
        if (e_wack) begin
            case (waddr)
                8'h00:   m_ctrl = wdata;
                8'h08:   clr = wdata[IRQ_W-1:0];
                8'h0C:   m_en = wdata[IRQ_W-1:0];
                8'h10:   m_scratch = wdata;
                8'h14:   cnt_clr = 1;
                default: e_waddrerr = 1'b1;
            endcase
        end
        m_stat = (m_stat & ~clr) | (irq_src_i & ~m_prev);
        m_prev = irq_src_i;
        if (cnt_clr) m_cnt = 0;
        else if (evt_i && m_cnt < CNT_MAX) m_cnt++;
        m_status = status_i;
        r_was_hi = rstrobe;
        w_was_hi = wstrobe;
    endtask

    task automatic compare_all();
        check("rack", 32'(rack), 32'(e_rack));
        check("rdata", rdata, e_rdata);
        check("raddrerr", 32'(raddrerr), 32'(e_raddrerr));
        check("wack", 32'(wack), 32'(e_wack));
        check("waddrerr", 32'(waddrerr), 32'(e_waddrerr));
        check("ctrl_o", ctrl_o, m_ctrl);
        check("irq_o", 32'(irq_o), 32'(e_irq));
    endtask

    // Inputs are changed at a falling edge; one tick advances to the next falling edge.
    task automatic tick();
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        wstrobe = 1'b1; waddr = a; wdata = d;
        tick();
        check("wack_latency", 32'(wack), 32'd1);
        tick();
        wstrobe = 1'b0;
        tick();
    endtask

    task automatic rd(input logic [7:0] a, output logic [31:0] d, output logic e);
        rstrobe = 1'b1; raddr = a;
        tick();
        check("rack_latency", 32'(rack), 32'd1);
        d = rdata;
        e = raddrerr;
        tick();
        rstrobe = 1'b0;
        tick();
    endtask

    function automatic logic [7:0] pick_addr();
        case ($urandom_range(0, 10))
            0: return 8'h00;
            1: return 8'h04;
            2: return 8'h08;
            3: return 8'h0C;
            4: return 8'h10;
            5: return 8'h14;
            6: return 8'h02;
            7: return 8'h40;
            8: return 8'h18;
            9: return 8'hFC;
            default: return 8'h0D;
        endcase
    endfunction

    int r_left = 0;
    int w_left = 0;

    task automatic rand_inputs();
        if (r_left == 0 && !rstrobe && $urandom_range(0, 2) == 0) begin
            r_left = $urandom_range(1, 5);
            raddr  = pick_addr();
        end
        rstrobe = (r_left != 0);
        if (r_left != 0) r_left--;
        if (w_left == 0 && !wstrobe && $urandom_range(0, 2) == 0) begin
            w_left = $urandom_range(1, 5);
            waddr  = pick_addr();
            wdata  = $urandom;
        end
        wstrobe = (w_left != 0);
        if (w_left != 0) w_left--;
        if ($urandom_range(0, 3) == 0) irq_src_i = irq_src_i ^ IRQ_W'($urandom);
        evt_i    = 1'($urandom);
        status_i = $urandom;
    endtask

    logic [31:0] d;
    logic        e;
    int          pulses;

    initial begin
        reset = 1'b1; rstrobe = 1'b0; raddr = '0; wstrobe = 1'b0; waddr = '0; wdata = '0;
        status_i = '0; irq_src_i = '0; evt_i = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        compare_all();
        reset = 1'b0;
        tick();

        // CTRL write and read-back
        wr(8'h00, 32'hA5A5_1234);
        check("ctrl_o_wr", ctrl_o, 32'hA5A5_1234);
        rd(8'h00, d, e);
        check("ctrl_rd", d, 32'hA5A5_1234);
        check("ctrl_rd_err", 32'(e), 32'd0);

        // Unmapped and illegal accesses
        rd(8'h40, d, e);
        check("rd40_data", d, 32'd0);
        check("rd40_err", 32'(e), 32'd1);
        wr(8'h04, 32'hFFFF_FFFF);
        check("wr04_err", 32'(waddrerr), 32'd0);
        wr(8'h02, 32'hDEAD_BEEF);
        rd(8'h02, d, e);
        check("rd02_data", d, 32'd0);
        check("rd02_err", 32'(e), 32'd1);
        rd(8'h00, d, e);
        check("ctrl_unchanged", d, 32'hA5A5_1234);

        // IRQ edge capture, enable, W1C, and set-beats-clear
        wr(8'h0C, 32'h0000_0008);
        irq_src_i[3] = 1'b1; tick();
        irq_src_i[3] = 1'b0; tick(); tick();
        rd(8'h08, d, e);
        check("irq_stat_set", d, 32'h08);
        check("irq_o_set", 32'(irq_o), 32'd1);
        wr(8'h08, 32'h0000_0008);
        tick();
        check("irq_o_clr", 32'(irq_o), 32'd0);
        wstrobe = 1'b1; waddr = 8'h08; wdata = 32'h08; irq_src_i[3] = 1'b1;
        tick(); tick();
        wstrobe = 1'b0; irq_src_i[3] = 1'b0;
        tick();
        rd(8'h08, d, e);
        check("irq_set_wins", d, 32'h08);

        // Long strobe on SCRATCH: single ack, single write
        pulses = 0;
        wstrobe = 1'b1; waddr = 8'h10; wdata = 32'h0BAD_F00D;
        repeat (4) begin
            tick();
            pulses += int'(wack);
        end
        wstrobe = 1'b0;
        tick();
        pulses += int'(wack);
        check("wack_once", 32'(pulses), 32'd1);
        rd(8'h10, d, e);
        check("scratch_rd", d, 32'h0BAD_F00D);

        // Counter saturation, then clear beating a coincident event
        evt_i = 1'b1;
        repeat (CNT_MAX + 20) tick();
        evt_i = 1'b0;
        rd(8'h14, d, e);
        check("cnt_sat", d, CNT_MAX);
        evt_i = 1'b1; wstrobe = 1'b1; waddr = 8'h14; wdata = 32'h1234;
        tick();
        evt_i = 1'b0;
        tick();
        wstrobe = 1'b0;
        tick();
        rd(8'h14, d, e);
        check("cnt_clr_wins", d, 32'd0);

        // Reset in the middle of a read access
        rstrobe = 1'b1; raddr = 8'h00;
        tick();
        reset = 1'b1;
        #1;
        model_reset();
        check("rst_rack", 32'(rack), 32'd0);
        check("rst_ctrl", ctrl_o, CTRL_RST);
        check("rst_irq", 32'(irq_o), 32'd0);
        tick();
        rstrobe = 1'b0; reset = 1'b0;
        tick();
        rd(8'h08, d, e);
        check("rst_irq_stat", d, 32'd0);

        // Randomized traffic against the model
        repeat (3000) begin
            rand_inputs();
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
